// File: rtl/hazard_scoreboard.sv
// Decode-stage issue controller: tracks pending register writes, stalls on RAW/WAW
// hazards and sequences write-back. Optional macro WB_BYPASS_EN frees the retiring register early.
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 2,
  parameter int WB_LATENCY = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [REG_ADDR_W-1:0]      id_rs1,
  input  logic [REG_ADDR_W-1:0]      id_rs2,
  input  logic                       id_uses_rs1,
  input  logic                       id_uses_rs2,
  input  logic [REG_ADDR_W-1:0]      id_rd,
  input  logic                       id_no_write,
  input  logic                       flush,
  output logic                       stall,
  output logic                       issue,
  output logic                       wb_we,
  output logic [REG_ADDR_W-1:0]      wb_reg,
  output logic [2**REG_ADDR_W-1:0]   busy_mask,
  output logic [2:0]                 inflight_cnt
);

  if (WB_LATENCY < 2 || WB_LATENCY > 7) begin : g_lat_check
    $error("hazard_scoreboard: WB_LATENCY must be within 2..7");
  end

`ifdef WB_BYPASS_EN
  localparam int BUSY_SLOTS = WB_LATENCY - 1;
`else
  localparam int BUSY_SLOTS = WB_LATENCY;
`endif

  logic [WB_LATENCY-1:0] vld_q, vld_d;
  logic [REG_ADDR_W-1:0] reg_q [WB_LATENCY];
  logic [REG_ADDR_W-1:0] reg_d [WB_LATENCY];
  logic                  hazard;
  logic [3:0]            cnt;

  assign wb_we  = vld_q[WB_LATENCY-1];
  assign wb_reg = vld_q[WB_LATENCY-1] ? reg_q[WB_LATENCY-1] : '0;

  always_comb begin
    busy_mask = '0;
    for (int k = 0; k < BUSY_SLOTS; k++) begin
      if (vld_q[k]) busy_mask[reg_q[k]] = 1'b1;
    end
  end

  // At most one pending write per register is guaranteed by the WAW term.
  assign hazard = (id_uses_rs1 & busy_mask[id_rs1]) |
                  (id_uses_rs2 & busy_mask[id_rs2]) |
                  (~id_no_write & busy_mask[id_rd]);

  assign stall = id_valid & hazard & ~flush & ~rst;
  assign issue = id_valid & ~hazard & ~flush & ~rst;

  always_comb begin
    cnt = '0;
    for (int k = 0; k < WB_LATENCY; k++) begin
      cnt = cnt + {3'b000, vld_q[k]};
    end
    inflight_cnt = (cnt > 4'd7) ? 3'd7 : cnt[2:0];
  end

  // A flush kills every younger slot; the retiring slot has already written back this cycle.
  always_comb begin
    vld_d = '0;
    for (int k = 0; k < WB_LATENCY; k++) reg_d[k] = '0;
    if (!flush) begin
      vld_d[0] = issue & ~id_no_write;
      reg_d[0] = id_rd;
      for (int k = 1; k < WB_LATENCY; k++) begin
        vld_d[k] = vld_q[k-1];
        reg_d[k] = reg_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      reg_q <= '{default: '0};
    end else begin
      vld_q <= vld_d;
      reg_q <= reg_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; expected write-backs are queued at issue and
// checked by a monitor when wb_we fires. Honors WB_BYPASS_EN when defined.
module tb_hazard_scoreboard;

  localparam int LAT = 3;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_uses_rs1, id_uses_rs2, id_no_write, flush;
  logic [1:0] id_rs1, id_rs2, id_rd;
  logic       stall, issue, wb_we;
  logic [1:0] wb_reg;
  logic [3:0] busy_mask;
  logic [2:0] inflight_cnt;

  hazard_scoreboard #(.REG_ADDR_W(2), .WB_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_no_write(id_no_write), .flush(flush), .stall(stall), .issue(issue),
    .wb_we(wb_we), .wb_reg(wb_reg), .busy_mask(busy_mask), .inflight_cnt(inflight_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] rd; int due; } wb_t;
  wb_t sb_q[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] rs1, input logic u1,
                       input logic [1:0] rs2, input logic u2, input logic [1:0] rd,
                       input logic nw, input logic fl);
    id_valid = v; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
    id_rd = rd; id_no_write = nw; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic expect_issue(input logic [1:0] rd);
    wb_t e;
    e.rd = rd; e.due = cyc + LAT;
    sb_q.push_back(e);
  endtask

  // Write-back monitor: every wb_we must match the oldest queued write at its due cycle.
  always @(negedge clk) begin
    wb_t e;
    if (wb_we === 1'b1) begin
      if (sb_q.size() == 0) chk("wb_unexpected", {31'b0, wb_we}, 32'd0);
      else begin
        e = sb_q.pop_front();
        chk("wb_reg", {30'b0, wb_reg}, {30'b0, e.rd});
        chk("wb_time", cyc, e.due);
      end
    end else if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      chk("wb_missing", {31'b0, wb_we}, 32'd1);
      void'(sb_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    sample();
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_issue", {31'b0, issue}, 32'd0);
    chk("rst_wb_we", {31'b0, wb_we}, 32'd0);
    chk("rst_wb_reg", {30'b0, wb_reg}, 32'd0);
    chk("rst_busy", {28'b0, busy_mask}, 32'd0);
    chk("rst_cnt", {29'b0, inflight_cnt}, 32'd0);
    step();
    rst = 1'b0;

    // RAW on r1: dependent read stalls until r1 is written back
    drive(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd1, 1'b0, 1'b0);
    sample();
    chk("raw_issue0", {31'b0, issue}, 32'd1);
    expect_issue(2'd1);
    step();
    drive(1'b1, 2'd1, 1'b1, 2'd0, 1'b0, 2'd3, 1'b0, 1'b0);
    for (int i = 1; i <= (BYP ? 3 : 4); i++) begin
      sample();
      if (i == (BYP ? 3 : 4)) begin
        chk("raw_issue", {31'b0, issue}, 32'd1);
        chk("raw_nostall", {31'b0, stall}, 32'd0);
        expect_issue(2'd3);
      end else begin
        chk("raw_stall", {31'b0, stall}, 32'd1);
        chk("raw_noissue", {31'b0, issue}, 32'd0);
        if (i == 1) chk("raw_busy", {28'b0, busy_mask}, 32'h2);
      end
      step();
    end
    idle();
    repeat (LAT + 1) step();

    // Immediate form: rs2 names a busy register but is not read
    drive(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd2, 1'b0, 1'b0);
    sample();
    expect_issue(2'd2);
    step();
    drive(1'b1, 2'd0, 1'b0, 2'd2, 1'b0, 2'd3, 1'b0, 1'b0);
    sample();
    chk("imm_busy", {28'b0, busy_mask}, 32'h4);
    chk("imm_stall", {31'b0, stall}, 32'd0);
    chk("imm_issue", {31'b0, issue}, 32'd1);
    expect_issue(2'd3);
    step();
    idle();
    repeat (LAT + 1) step();

    // Back-to-back independent writes r0, r1, r2
    for (int r = 0; r < 3; r++) begin
      drive(1'b1, 2'd3, 1'b1, 2'd3, 1'b1, 2'(r), 1'b0, 1'b0);
      sample();
      chk("b2b_issue", {31'b0, issue}, 32'd1);
      expect_issue(2'(r));
      step();
    end
    idle();
    sample();
    chk("b2b_cnt", {29'b0, inflight_cnt}, 32'd3);
    chk("b2b_busy", {28'b0, busy_mask}, BYP ? 32'h6 : 32'h7);
    repeat (3) step();
    sample();
    chk("b2b_drained_cnt", {29'b0, inflight_cnt}, 32'd0);
    chk("b2b_drained_busy", {28'b0, busy_mask}, 32'd0);
    step();

    // WAW: second write to r2 stalls while the first is pending
    drive(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd2, 1'b0, 1'b0);
    sample();
    expect_issue(2'd2);
    step();
    drive(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd2, 1'b0, 1'b0);
    sample();
    chk("waw_stall", {31'b0, stall}, 32'd1);
    step();
    idle();
    repeat (LAT + 1) step();

    // Flush kills r1 and r2; flush also beats a hazarding decode
    drive(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd1, 1'b0, 1'b0);
    sample();
    expect_issue(2'd1);
    step();
    drive(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd2, 1'b0, 1'b0);
    sample();
    expect_issue(2'd2);
    step();
    drive(1'b1, 2'd1, 1'b1, 2'd0, 1'b0, 2'd3, 1'b0, 1'b1);
    sample();
    chk("flush_issue", {31'b0, issue}, 32'd0);
    chk("flush_stall", {31'b0, stall}, 32'd0);
    while (sb_q.size() > 0 && sb_q[$].due > cyc) void'(sb_q.pop_back());
    step();
    idle();
    sample();
    chk("flush_busy", {28'b0, busy_mask}, 32'd0);
    chk("flush_cnt", {29'b0, inflight_cnt}, 32'd0);
    repeat (LAT + 1) step();

    // Reset mid-run with two writes pending
    drive(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    sample();
    expect_issue(2'd0);
    step();
    drive(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd1, 1'b0, 1'b0);
    sample();
    expect_issue(2'd1);
    step();
    idle();
    sample();
    chk("pre_rst_cnt", {29'b0, inflight_cnt}, 32'd2);
    #1;
    rst = 1'b1;
    sb_q.delete();
    #1;
    chk("mid_rst_wb_we", {31'b0, wb_we}, 32'd0);
    chk("mid_rst_busy", {28'b0, busy_mask}, 32'd0);
    chk("mid_rst_cnt", {29'b0, inflight_cnt}, 32'd0);
    step();
    rst = 1'b0;
    repeat (LAT + 2) step();

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
